// File: rtl/serial_subtractor_pkg.sv
// Shared types and limits for the bit-serial subtractor.
// Provides the FSM state encoding and the signed-overflow helper.
package sub_pkg;

  localparam int SUB_MAX_WIDTH = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Overflow is only possible when the operand signs differ.
  function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic d_msb);
    ovf_flag = (a_msb ^ b_msb) ? (d_msb ^ a_msb) : 1'b0;
  endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built from two cascaded half subtractors.
// d = x - y - bin, with bo set when a borrow propagates out.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);
  assign d  = x ^ y;
  assign bo = ~x & y;
endmodule

module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);
  logic d1_s;
  logic b1_s;
  logic b2_s;

  half_subtractor u_hs0 (.x(x),    .y(y),   .d(d1_s), .bo(b1_s));
  half_subtractor u_hs1 (.x(d1_s), .y(bin), .d(d),    .bo(b2_s));

  assign bo = b1_s | b2_s;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock with a registered borrow.
// Results and flags are held until the next accepted start.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);
  localparam int              CNT_W   = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] diff_r;
  logic [CNT_W-1:0] cnt_r;
  logic             borrow_r;
  logic             a_msb_r;
  logic             b_msb_r;
  logic             busy_r;
  logic             done_r;
  logic             bout_r;
  logic             ovf_r;
  logic             d_s;
  logic             bo_s;

  full_subtractor u_fs (
    .x  (a_r[0]),
    .y  (b_r[0]),
    .bin(borrow_r),
    .d  (d_s),
    .bo (bo_s)
  );

  // Control FSM, operand shift registers, counter and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      diff_r   <= '0;
      cnt_r    <= '0;
      borrow_r <= 1'b0;
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      bout_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            a_msb_r  <= a[WIDTH-1];
            b_msb_r  <= b[WIDTH-1];
            borrow_r <= 1'b0;
            cnt_r    <= '0;
            diff_r   <= '0;
            busy_r   <= 1'b1;
            state_r  <= RUN;
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          diff_r   <= {d_s, diff_r[WIDTH-1:1]};
          a_r      <= {1'b0, a_r[WIDTH-1:1]};
          b_r      <= {1'b0, b_r[WIDTH-1:1]};
          borrow_r <= bo_s;
          cnt_r    <= cnt_r + CNT_ONE;
          // d_s on the last bit is the sign bit of the result.
          if (cnt_r == CNT_LAST) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            bout_r  <= bo_s;
            ovf_r   <= ovf_flag(a_msb_r, b_msb_r, d_s);
          end else begin
            state_r <= RUN;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign diff = diff_r;
  assign bout = bout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed vectors with
// hand-computed results, checked by a monitor whenever done pulses.
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bo;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   busy_cnt = 0;
  int   done_seen = 0;
  int   pushed = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse, also checks busy length.
  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    if (done) begin
      done_seen++;
      check("busy_cycles", busy_cnt, W);
      busy_cnt = 0;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got diff %0h with empty scoreboard", diff);
      end else begin
        e = q.pop_front();
        check("diff", diff, e.d);
        check("bout", bout, e.bo);
        check("ovf", ovf, e.ov);
      end
    end else if (!busy) begin
      busy_cnt = 0;
    end
  end

  // Drive a start pulse; returns in the first busy cycle.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] d, input logic bo, input logic ov,
                       input bit expect_done);
    exp_t e;
    a = av;
    b = bv;
    start = 1'b1;
    if (expect_done) begin
      e.d = d; e.bo = bo; e.ov = ov;
      q.push_back(e);
      pushed++;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for done; elapsed counts busy cycles already spent after issue().
  task automatic wait_done(input int elapsed);
    int n = elapsed;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, W);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_bout", bout, 1'b0);
    check("rst_ovf", ovf, 1'b0);

    issue(8'd100, 8'd37, 8'd63, 1'b0, 1'b0, 1'b1);
    check("busy_after_start", busy, 1'b1);
    wait_done(0);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("diff_held", diff, 8'd63);

    issue(8'd5, 8'd9, 8'hFC, 1'b1, 1'b0, 1'b1);
    wait_done(0);
    issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b1);
    wait_done(0);
    issue(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b1);
    wait_done(0);
    @(negedge clk);

    // Start pulsed mid-run must be ignored.
    issue(8'd200, 8'd50, 8'h96, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    a = 8'd1; b = 8'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h33; b = 8'h44;
    wait_done(2);
    repeat (3) @(negedge clk);
    check("ignored_start_idle", busy, 1'b0);
    check("ignored_start_diff", diff, 8'h96);

    // Reset in the 4th busy cycle aborts without done.
    issue(8'd10, 8'd3, 8'h00, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_diff", diff, 8'h00);
    check("abort_done", done, 1'b0);
    repeat (12) @(negedge clk);
    check("abort_no_done", done_seen, pushed);

    issue(8'hAA, 8'hAA, 8'h00, 1'b0, 1'b0, 1'b1);
    wait_done(0);

    // Back-to-back: start in the done cycle is accepted.
    issue(8'd1, 8'd0, 8'd1, 1'b0, 1'b0, 1'b1);
    wait_done(0);
    issue(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    wait_done(0);
    issue(8'd0, 8'hFF, 8'd1, 1'b1, 1'b0, 1'b1);
    wait_done(0);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    check("done_count", done_seen, pushed);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
